// File: rtl/alu_flag_pkg.sv
// ----------------------------------------------------------------------------
// alu_flag_pkg
// Purpose : Shared type for the ALU flag register output consumed by the
//           branch controller. Carry is not part of this struct; it reaches
//           branch_ctrl on its own line after force-masking in the flag block.
// ----------------------------------------------------------------------------
package alu_flag_pkg;

    typedef struct packed {
        logic zero;
        logic sign;
        logic overflow;
    } struct_alu_flag_t;

endpackage

// File: rtl/branch_ctrl.sv
// ----------------------------------------------------------------------------
// branch_ctrl
// Purpose : Resolves conditional-branch requests against the ALU flags and
//           drives the program counter. A taken branch loads the target,
//           flushes fetch for FLUSH_CYC cycles and requests a flag clear.
//
// Parameters:
//   ADDR_W    PC / branch target width
//   RESET_PC  PC value after reset
//   FLUSH_CYC cycles oflush stays high after a taken branch (>=1)
//
// Ports:
//   iclk, irst        clock, synchronous active-high reset
//   istep             advance PC by one (sequential fetch), honoured in IDLE only
//   ibr_valid/obr_ready  branch request handshake; obr_ready decoded from state
//   ibr_cond          4-bit condition code
//   ibr_target        branch target address
//   iflag, icarry     flag register output and (force-masked) carry
//   opc               current program counter
//   otaken/onot_taken/oillegal  1-cycle resolution pulses
//   oflush            fetch flush after a taken branch
//   oclf              1-cycle flag-clear request, coincident with otaken
//
// Optional feature (macro BRANCH_CTRL_STATS_EN):
//   otaken_cnt, onot_taken_cnt  saturating 16-bit resolution counters,
//   cleared only by irst. Reserved condition codes count as not taken.
// ----------------------------------------------------------------------------
module branch_ctrl
    import alu_flag_pkg::*;
#(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int                 FLUSH_CYC = 2
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  istep,
    input  logic                  ibr_valid,
    output logic                  obr_ready,
    input  logic [3:0]            ibr_cond,
    input  logic [ADDR_W-1:0]     ibr_target,
    input  struct_alu_flag_t      iflag,
    input  logic                  icarry,
`ifdef BRANCH_CTRL_STATS_EN
    output logic [15:0]           otaken_cnt,
    output logic [15:0]           onot_taken_cnt,
`endif
    output logic [ADDR_W-1:0]     opc,
    output logic                  otaken,
    output logic                  onot_taken,
    output logic                  oillegal,
    output logic                  oflush,
    output logic                  oclf
);

    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc,     w_pc_nxt;
    logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    logic [3:0]          r_cond;
    logic [ADDR_W-1:0]   r_target;
    logic                r_z, r_n, r_v, r_c;
    logic                r_taken,     w_taken_nxt;
    logic                r_not_taken, w_not_taken_nxt;
    logic                r_illegal,   w_illegal_nxt;
    logic                r_flush,     w_flush_nxt;
    logic                w_accept;
    logic                w_hit;

    // Condition table on the latched flags; 13 (never) and reserved 14/15 miss.
    function automatic logic cond_hit(input logic [3:0] cond,
                                      input logic c, input logic z,
                                      input logic n, input logic v);
        logic hit;
        hit = 1'b0;
        case (cond)
            4'd0:    hit = 1'b1;
            4'd1:    hit = z;
            4'd2:    hit = ~z;
            4'd3:    hit = c;
            4'd4:    hit = ~c;
            4'd5:    hit = n;
            4'd6:    hit = ~n;
            4'd7:    hit = v;
            4'd8:    hit = ~v;
            4'd9:    hit = c & ~z;
            4'd10:   hit = ~c | z;
            4'd11:   hit = (n == v);
            4'd12:   hit = (n != v);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign w_hit     = cond_hit(r_cond, r_c, r_z, r_n, r_v);
    assign obr_ready = (r_state == IDLE);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_cnt_nxt       = r_cnt;
        w_taken_nxt     = 1'b0;
        w_not_taken_nxt = 1'b0;
        w_illegal_nxt   = 1'b0;
        w_flush_nxt     = 1'b0;
        w_accept        = 1'b0;
        case (r_state)
            IDLE: begin
                // A branch request wins over a simultaneous step.
                if (ibr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EVAL;
                end else if (istep) begin
                    w_pc_nxt = r_pc + ADDR_W'(1);
                end
            end
            EVAL: begin
                if (w_hit) begin
                    w_pc_nxt    = r_target;
                    w_taken_nxt = 1'b1;
                    w_flush_nxt = 1'b1;
                    w_cnt_nxt   = CNT_W'(FLUSH_CYC - 1);
                    w_state_nxt = FLUSH;
                end else begin
                    w_pc_nxt        = r_pc + ADDR_W'(1);
                    w_not_taken_nxt = 1'b1;
                    w_illegal_nxt   = (r_cond >= 4'd14);
                    w_state_nxt     = IDLE;
                end
            end
            FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_flush_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_cnt       <= '0;
            r_cond      <= '0;
            r_target    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_c         <= 1'b0;
            r_taken     <= 1'b0;
            r_not_taken <= 1'b0;
            r_illegal   <= 1'b0;
            r_flush     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_taken     <= w_taken_nxt;
            r_not_taken <= w_not_taken_nxt;
            r_illegal   <= w_illegal_nxt;
            r_flush     <= w_flush_nxt;
            // Flags are captured at accept so later flag changes cannot
            // alter the decision made in EVAL.
            if (w_accept) begin
                r_cond   <= ibr_cond;
                r_target <= ibr_target;
                r_z      <= iflag.zero;
                r_n      <= iflag.sign;
                r_v      <= iflag.overflow;
                r_c      <= icarry;
            end
        end
    end

    assign opc        = r_pc;
    assign otaken     = r_taken;
    assign onot_taken = r_not_taken;
    assign oillegal   = r_illegal;
    assign oflush     = r_flush;
    assign oclf       = r_taken;

`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_not_taken_cnt;

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_taken_cnt     <= '0;
            r_not_taken_cnt <= '0;
        end else begin
            if (w_taken_nxt && (r_taken_cnt != 16'hFFFF))
                r_taken_cnt <= r_taken_cnt + 16'd1;
            if (w_not_taken_nxt && (r_not_taken_cnt != 16'hFFFF))
                r_not_taken_cnt <= r_not_taken_cnt + 16'd1;
        end
    end

    assign otaken_cnt     = r_taken_cnt;
    assign onot_taken_cnt = r_not_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
    import alu_flag_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int FLUSH_CYC = 2;

    logic                iclk = 1'b0;
    logic                irst = 1'b1;
    logic                istep = 1'b0;
    logic                ibr_valid = 1'b0;
    logic                obr_ready;
    logic [3:0]          ibr_cond = '0;
    logic [ADDR_W-1:0]   ibr_target = '0;
    struct_alu_flag_t    iflag = '0;
    logic                icarry = 1'b0;
    logic [ADDR_W-1:0]   opc;
    logic                otaken, onot_taken, oillegal, oflush, oclf;
`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0]         otaken_cnt, onot_taken_cnt;
`endif

    branch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(8'h00), .FLUSH_CYC(FLUSH_CYC)) dut (
        .iclk(iclk), .irst(irst), .istep(istep),
        .ibr_valid(ibr_valid), .obr_ready(obr_ready),
        .ibr_cond(ibr_cond), .ibr_target(ibr_target),
        .iflag(iflag), .icarry(icarry),
`ifdef BRANCH_CTRL_STATS_EN
        .otaken_cnt(otaken_cnt), .onot_taken_cnt(onot_taken_cnt),
`endif
        .opc(opc), .otaken(otaken), .onot_taken(onot_taken),
        .oillegal(oillegal), .oflush(oflush), .oclf(oclf)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: expected PC and resolution counts since last reset.
    logic [ADDR_W-1:0] m_pc;
    int m_tk;
    int m_nt;

    // Expected branch decision straight from the condition table.
    function automatic bit ref_taken(input int cond, input bit c, input bit z,
                                     input bit n, input bit v);
        case (cond)
            0:  return 1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return !c;
            5:  return n;
            6:  return !n;
            7:  return v;
            8:  return !v;
            9:  return c && !z;
            10: return !c || z;
            11: return n == v;
            12: return n != v;
            default: return 0;
        endcase
    endfunction

    // Advance one clock; outputs are inspected 1 time unit after the edge.
    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Output bundle: {otaken, onot_taken, oillegal, oclf, oflush, obr_ready}
    function automatic logic [5:0] outs();
        return {otaken, onot_taken, oillegal, oclf, oflush, obr_ready};
    endfunction

    task automatic do_reset();
        irst = 1'b1; istep = 1'b1; ibr_valid = 1'b1;
        tick();
        irst = 1'b0; istep = 1'b0; ibr_valid = 1'b0;
        m_pc = 8'h00; m_tk = 0; m_nt = 0;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            istep = 1'b1;
            tick();
            m_pc = m_pc + 8'd1;
            n_checks++;
            if (opc !== m_pc) begin
                n_fail++;
                $display("FAIL step_pc: opc=%h expected %h", opc, m_pc);
            end
        end
        istep = 1'b0;
    endtask

    // One complete branch transaction from IDLE, with flags inverted right
    // after accept to prove the decision uses the values seen at accept.
    task automatic do_branch(input int cond, input logic [7:0] tgt,
                             input bit z, input bit n, input bit v, input bit c,
                             input bit step_too);
        bit tk, ill;
        logic [5:0] exp;
        tk  = ref_taken(cond, c, z, n, v);
        ill = (cond >= 14);
        ibr_valid = 1'b1; ibr_cond = 4'(cond); ibr_target = tgt;
        iflag.zero = z; iflag.sign = n; iflag.overflow = v; icarry = c;
        istep = step_too;
        tick();
        ibr_valid = 1'b0; istep = 1'($urandom_range(0, 1));
        iflag.zero = !z; iflag.sign = !n; iflag.overflow = !v; icarry = !c;
        ibr_cond = 4'($urandom); ibr_target = 8'($urandom);
        n_checks++;
        if (outs() !== 6'b000000 || opc !== m_pc) begin
            n_fail++;
            $display("FAIL accept_cycle: outs=%b opc=%h expected 000000 %h", outs(), opc, m_pc);
        end
        tick();
        m_pc = tk ? tgt : m_pc + 8'd1;
        if (tk) m_tk++; else m_nt++;
        exp = {tk, !tk, ill, tk, tk, !tk};
        n_checks++;
        if (outs() !== exp || opc !== m_pc) begin
            n_fail++;
            $display("FAIL resolve cond=%0d: outs=%b opc=%h expected %b %h", cond, outs(), opc, exp, m_pc);
        end
        if (tk) begin
            for (int k = 1; k < FLUSH_CYC; k++) begin
                tick();
                n_checks++;
                if (outs() !== 6'b000010 || opc !== m_pc) begin
                    n_fail++;
                    $display("FAIL flush_hold: outs=%b opc=%h expected 000010 %h", outs(), opc, m_pc);
                end
            end
            tick();
            n_checks++;
            if (outs() !== 6'b000001 || opc !== m_pc) begin
                n_fail++;
                $display("FAIL flush_end: outs=%b opc=%h expected 000001 %h", outs(), opc, m_pc);
            end
        end
        istep = 1'b0;
    endtask

    task automatic test_reset();
        irst = 1'b1;
        tick(); tick();
        n_checks++;
        if (opc !== 8'h00 || outs() !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_state: opc=%h outs=%b expected 00 000001", opc, outs());
        end
        irst = 1'b0;
        m_pc = 8'h00; m_tk = 0; m_nt = 0;
    endtask

    task automatic test_step();
        step_n(3);
        do_reset();
        n_checks++;
        if (opc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_from_3: opc=%h expected 00", opc);
        end
    endtask

    task automatic test_taken();
        do_reset();
        do_branch(1, 8'h40, 1, 0, 0, 0, 0);
    endtask

    task automatic test_not_taken();
        do_reset();
        step_n(16);
        do_branch(3, 8'h77, 0, 1, 1, 0, 0);
    endtask

    task automatic test_wrap_and_collision();
        do_reset();
        do_branch(0, 8'hFF, 0, 0, 0, 0, 0);
        step_n(1);
        do_branch(13, 8'h20, 1, 1, 1, 1, 1);
        n_checks++;
        if (opc !== 8'h01) begin
            n_fail++;
            $display("FAIL step_with_accept: opc=%h expected 01", opc);
        end
    endtask

    task automatic test_illegal();
        do_branch(14, 8'h55, 1, 1, 1, 1, 0);
        do_branch(15, 8'h66, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_flush();
        ibr_valid = 1'b1; ibr_cond = 4'd0; ibr_target = 8'hA0;
        tick();
        ibr_valid = 1'b0;
        tick();
        irst = 1'b1;
        tick();
        irst = 1'b0;
        m_pc = 8'h00; m_tk = 0; m_nt = 0;
        n_checks++;
        if (opc !== 8'h00 || outs() !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_mid_flush: opc=%h outs=%b expected 00 000001", opc, outs());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0)
                step_n(int'($urandom_range(1, 4)));
            else
                do_branch(int'($urandom_range(0, 15)), 8'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom));
        end
    endtask

    task automatic test_stats();
`ifdef BRANCH_CTRL_STATS_EN
        n_checks++;
        if (otaken_cnt !== 16'(m_tk) || onot_taken_cnt !== 16'(m_nt)) begin
            n_fail++;
            $display("FAIL stats_random: cnt=%0d/%0d expected %0d/%0d", otaken_cnt, onot_taken_cnt, m_tk, m_nt);
        end
        do_reset();
        n_checks++;
        if (otaken_cnt !== 16'd0 || onot_taken_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset: cnt=%0d/%0d expected 0/0", otaken_cnt, onot_taken_cnt);
        end
        do_branch(0, 8'h10, 0, 0, 0, 0, 0);
        do_branch(1, 8'h20, 1, 0, 0, 0, 0);
        do_branch(2, 8'h30, 0, 0, 0, 0, 0);
        do_branch(13, 8'h40, 0, 0, 0, 0, 0);
        do_branch(14, 8'h50, 0, 0, 0, 0, 0);
        n_checks++;
        if (otaken_cnt !== 16'd3 || onot_taken_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_3_2: cnt=%0d/%0d expected 3/2", otaken_cnt, onot_taken_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_step();
        test_taken();
        test_not_taken();
        test_wrap_and_collision();
        test_illegal();
        test_reset_mid_flush();
        test_random();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
